// File: rtl/proc_multicycle.sv
// Multicycle 8-register CPU: FETCH -> EXEC (-> MEM) -> FETCH, retire pulses one cycle after completion.
// 2 cycles per ALU/branch op and 3 per load/store with zero-wait memories; code_ready/data_ready stall in place.
module proc_multicycle #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int RESET_IP  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 code_req,
    output logic [ADDR_SIZE-1:0] code_addr,
    input  logic                 code_ready,
    input  logic [WORD_SIZE-1:0] code_word,
    output logic                 data_req,
    output logic                 data_we,
    output logic [ADDR_SIZE-1:0] data_addr,
    output logic [WORD_SIZE-1:0] data_wdata,
    input  logic                 data_ready,
    input  logic [WORD_SIZE-1:0] data_rdata,
    output logic                 retire,
    output logic                 halted
);
    localparam int W = WORD_SIZE;
    localparam int A = ADDR_SIZE;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t         state;
    logic [A-1:0]   ip;
    logic [W-1:0]   ir;
    logic [W-1:0]   regs [8];

    logic [3:0]     op;
    logic [2:0]     rx_i, ry_i, f;
    logic [W-1:0]   rxv, ryv, imm8, imm_l_sext, link, wb_val;
    logic [A-1:0]   ip_inc, ip_next, br_tgt, ea;
    logic           wb_en;

    assign op         = ir[W-1:W-4];
    assign rx_i       = ir[W-5:W-7];
    assign ry_i       = ir[W-8:W-10];
    assign f          = ir[2:0];
    assign rxv        = regs[rx_i];
    assign ryv        = regs[ry_i];
    assign imm8       = {{(W-8){ir[7]}}, ir[7:0]};
    assign imm_l_sext = {{7{ir[W-8]}}, ir[W-8:0]};
    assign ip_inc     = ip + 1'b1;
    assign link       = W'(ip_inc);
    assign br_tgt     = ip_inc + imm_l_sext[A-1:0];
    assign ea         = ryv[A-1:0] + imm8[A-1:0];
    assign code_addr  = ip;

    always_comb begin
        wb_val  = '0;
        wb_en   = 1'b0;
        ip_next = ip_inc;
        case (op)
            4'd0: begin wb_en = 1'b1; wb_val = ryv + imm8; end
            4'd1: begin wb_en = 1'b1; wb_val = imm_l_sext; end
            4'd2: begin wb_en = 1'b1; wb_val = {ir[W-8:0], 7'b0}; end
            4'd3: begin
                wb_en = 1'b1;
                case (f)
                    3'd0:    wb_val = rxv + ryv;
                    3'd1:    wb_val = rxv - ryv;
                    3'd2:    wb_val = rxv & ryv;
                    3'd3:    wb_val = rxv | ryv;
                    3'd4:    wb_val = rxv ^ ryv;
                    3'd5:    wb_val = rxv << 1;
                    3'd6:    wb_val = rxv >> 1;
                    default: wb_val = ryv;
                endcase
            end
            4'd6: if (rxv == '0) ip_next = br_tgt;
            // Target comes from the pre-write ry, so rx == ry still jumps to the old value.
            4'd7: begin wb_en = 1'b1; wb_val = link; ip_next = ryv[A-1:0]; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FETCH;
            ip         <= A'(RESET_IP);
            ir         <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            code_req   <= 1'b1;
            retire     <= 1'b0;
            halted     <= 1'b0;
            data_req   <= 1'b0;
            data_we    <= 1'b0;
            data_addr  <= '0;
            data_wdata <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: if (code_ready) begin
                    ir       <= code_word;
                    code_req <= 1'b0;
                    state    <= EXEC;
                end
                EXEC: case (op)
                    4'd4, 4'd5: begin
                        data_req   <= 1'b1;
                        data_we    <= (op == 4'd5);
                        data_addr  <= ea;
                        data_wdata <= rxv;
                        state      <= MEM;
                    end
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7: begin
                        if (wb_en) regs[rx_i] <= wb_val;
                        ip       <= ip_next;
                        retire   <= 1'b1;
                        code_req <= 1'b1;
                        state    <= FETCH;
                    end
                    default: begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end
                endcase
                MEM: if (data_ready) begin
                    if (!data_we) regs[rx_i] <= data_rdata;
                    ip       <= ip_inc;
                    retire   <= 1'b1;
                    data_req <= 1'b0;
                    code_req <= 1'b1;
                    state    <= FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_multicycle.sv
// Scoreboard bench: programs push expected fetch addresses and data accesses; a negedge monitor
// plays code/data memory and pops/compares each handshake.
module tb_proc_multicycle;
    localparam int W = 18;
    localparam int A = 18;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         code_req, data_req, data_we, retire, halted;
    logic [A-1:0] code_addr, data_addr;
    logic [W-1:0] data_wdata;
    logic         code_ready = 1'b0, data_ready = 1'b0;
    logic [W-1:0] code_word = '0, data_rdata = '0;

    proc_multicycle #(.ADDR_SIZE(A), .WORD_SIZE(W), .RESET_IP(0)) dut (
        .clock(clock), .reset(reset),
        .code_req(code_req), .code_addr(code_addr), .code_ready(code_ready), .code_word(code_word),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .retire(retire), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct { logic we; logic [A-1:0] addr; logic [W-1:0] wdata; } dtx_t;
    typedef struct { int src; int ry; int f; logic [W-1:0] exp; } alu_t;

    logic [W-1:0] cmem [int];
    logic [W-1:0] dmem [int];
    logic [A-1:0] exp_fetch [$];
    dtx_t         exp_data [$];
    int           retire_cyc [$];
    int n_cmp = 0, n_bad = 0, cyc = 0, retire_cnt = 0, n_instr = 0;
    int code_wait = 0, data_wait = 0, cw_cnt = 0, dw_cnt = 0, data_cyc = 0;
    bit noisy = 0, allow_extra = 0;
    logic [A-1:0] pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ins(input int op, input int rx, input int ry, input int imm);
        logic [3:0] o; logic [2:0] x, y; logic [7:0] i;
        o = op[3:0]; x = rx[2:0]; y = ry[2:0]; i = imm[7:0];
        return {o, x, y, i};
    endfunction

    function automatic logic [W-1:0] insl(input int op, input int rx, input int imm);
        logic [3:0] o; logic [2:0] x; logic [10:0] i;
        o = op[3:0]; x = rx[2:0]; i = imm[10:0];
        return {o, x, i};
    endfunction

    task automatic emit(input logic [W-1:0] w);
        cmem[int'(pc)] = w;
        exp_fetch.push_back(pc);
        if (w[W-1:W-4] < 4'd8) n_instr++;
        pc = pc + 1'b1;
    endtask

    task automatic exp_tx(input logic we, input int addr, input logic [W-1:0] wdata);
        dtx_t t;
        t.we = we; t.addr = A'(addr); t.wdata = wdata;
        exp_data.push_back(t);
    endtask

    // Memory responders and scoreboard monitor, all on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (!reset && retire) begin
            retire_cnt++;
            retire_cyc.push_back(cyc);
        end
        if (code_req) begin
            code_ready = (cw_cnt >= code_wait);
            code_word  = cmem.exists(int'(code_addr)) ? cmem[int'(code_addr)] : 18'h3C000;
            cw_cnt++;
        end else begin
            cw_cnt = 0; code_ready = noisy; code_word = 18'h3C000;
        end
        if (data_req) begin
            data_ready = (dw_cnt >= data_wait);
            data_rdata = dmem.exists(int'(data_addr)) ? dmem[int'(data_addr)] : '0;
            dw_cnt++;
        end else begin
            dw_cnt = 0; data_ready = noisy; data_rdata = 18'h15555;
        end
        if (reset) begin
            data_cyc = 0;
        end else begin
            if (code_req && code_ready) begin
                if (exp_fetch.size() > 0) chk("fetch_addr", code_addr, exp_fetch.pop_front());
                else if (!allow_extra) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_fetch: got addr 0x%0h, expected none", code_addr);
                end
            end
            if (data_req) begin
                if (exp_data.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_data: got addr 0x%0h, expected none", data_addr);
                end else begin
                    chk("data_we", data_we, exp_data[0].we);
                    chk("data_addr", data_addr, exp_data[0].addr);
                    if (exp_data[0].we) chk("data_wdata", data_wdata, exp_data[0].wdata);
                    data_cyc++;
                    if (data_ready) begin
                        chk("data_req_cycles", data_cyc, data_wait + 1);
                        void'(exp_data.pop_front());
                        data_cyc = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        exp_fetch.delete(); exp_data.delete(); cmem.delete(); retire_cyc.delete();
        pc = '0; retire_cnt = 0; n_instr = 0; allow_extra = 0;
    endtask

    task automatic release_check();
        reset = 1'b0;
        #1;
        chk("rst_code_req", code_req, 1);
        chk("rst_ip", code_addr, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_data_req", data_req, 0);
        chk("rst_data_we", data_we, 0);
        chk("rst_data_addr", data_addr, 0);
        chk("rst_data_wdata", data_wdata, 0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_fetch.size() + exp_data.size()) != 0 && n < 2000) begin
            tick(); n++;
        end
        chk(name, exp_fetch.size() + exp_data.size(), 0);
    endtask

    alu_t tbl [12] = '{
        '{4, 5, 0, 18'h0012C}, '{4, 5, 1, 18'h000B4}, '{4, 5, 2, 18'h00030}, '{4, 5, 3, 18'h000FC},
        '{4, 5, 4, 18'h000CC}, '{4, 5, 5, 18'h001E0}, '{4, 5, 6, 18'h00078}, '{4, 5, 7, 18'h0003C},
        '{5, 4, 1, 18'h3FF4C}, '{3, 5, 5, 18'h3FF00}, '{3, 5, 6, 18'h1FFC0}, '{3, 3, 0, 18'h3FF00}
    };

    initial begin
        logic [A-1:0] p;
        int n;

        // Program A: every op class, zero-wait memories, ends on an illegal opcode.
        do_reset();
        dmem[32'h50] = 18'h2ABCD;
        emit(insl(1, 1, 5));
        emit(ins(0, 2, 1, 8'hFD));
        emit(ins(5, 2, 0, 0));          exp_tx(1, 0, 18'd2);
        emit(insl(2, 3, 11'h7FF));
        emit(ins(5, 3, 0, 1));          exp_tx(1, 1, 18'h3FF80);
        emit(insl(1, 4, 11'h0F0));
        emit(insl(1, 5, 11'h03C));
        for (int k = 0; k < 12; k++) begin
            emit(ins(3, 6, tbl[k].src, 7));
            emit(ins(3, 6, tbl[k].ry, tbl[k].f));
            emit(ins(5, 6, 0, k + 2));  exp_tx(1, k + 2, tbl[k].exp);
        end
        emit(ins(4, 7, 5, 8'h14));      exp_tx(0, 32'h50, '0);
        emit(ins(5, 7, 0, 8'h60));      exp_tx(1, 32'h60, 18'h2ABCD);
        emit(ins(5, 5, 4, 8'hF0));      exp_tx(1, 32'hE0, 18'h0003C);
        emit(insl(1, 2, 11'h100));
        p = pc;
        emit(ins(7, 1, 2, 0));
        pc = 18'h100;
        emit(ins(5, 1, 0, 8'h70));      exp_tx(1, 32'h70, W'(p + 1'b1));
        emit(insl(1, 3, 11'h104));
        emit(ins(7, 3, 3, 0));
        pc = 18'h104;
        emit(ins(5, 3, 0, 8'h71));      exp_tx(1, 32'h71, 18'h103);
        emit(insl(6, 0, 3));
        pc = 18'h109;
        emit(insl(6, 3, 5));
        emit(18'h3C000);
        release_check();
        wait_done("progA_drain");
        repeat (10) tick();
        chk("progA_halted", halted, 1);
        chk("progA_halt_code_req", code_req, 0);
        chk("progA_retire_count", retire_cnt, n_instr);
        chk("progA_retire_gap_alu", retire_cyc[1] - retire_cyc[0], 2);
        chk("progA_retire_gap_mem", retire_cyc[2] - retire_cyc[1], 3);

        // Program B: wait states, stray ready strobes, jump to top of memory and self-loop branch.
        do_reset();
        noisy = 1; code_wait = 1; data_wait = 3;
        emit(insl(1, 1, 11'h012));
        emit(insl(1, 2, 2));
        emit(ins(5, 1, 2, 4));          exp_tx(1, 6, 18'h12);
        emit(insl(1, 5, 11'h7FF));
        emit(ins(7, 6, 5, 0));
        pc = 18'h3FFFF;
        emit(insl(6, 0, 11'h7FF));
        exp_fetch.push_back(18'h3FFFF);
        exp_fetch.push_back(18'h3FFFF);
        allow_extra = 1;
        release_check();
        wait_done("progB_drain");
        chk("progB_retire_count", retire_cnt >= 6, 1);

        // Program B2: same branch with r0 != 0 falls through and wraps ip to 0.
        do_reset();
        noisy = 0; code_wait = 0; data_wait = 0;
        emit(insl(1, 0, 1));
        emit(insl(1, 5, 11'h7FF));
        emit(ins(7, 6, 5, 0));
        pc = 18'h3FFFF;
        emit(insl(6, 0, 11'h7FF));
        exp_fetch.push_back(18'h0);
        allow_extra = 1;
        release_check();
        wait_done("progB2_drain");

        // Program C: reset while a load is stalled in MEM.
        do_reset();
        data_wait = 100;
        dmem[32'h30] = 18'h155;
        emit(insl(1, 1, 7));
        emit(ins(4, 1, 0, 8'h30));      exp_tx(0, 32'h30, '0);
        release_check();
        n = 0;
        while (!data_req && n < 50) begin tick(); n++; end
        chk("progC_mem_reached", data_req, 1);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("progC_rst_data_req", data_req, 0);
        chk("progC_rst_code_req", code_req, 1);
        chk("progC_rst_retire", retire, 0);

        // Program D: registers cleared by reset, then halt at ip 4.
        do_reset();
        data_wait = 0;
        emit(ins(5, 1, 0, 8'h31));      exp_tx(1, 32'h31, '0);
        emit(ins(0, 0, 0, 0));
        emit(ins(0, 0, 0, 0));
        emit(ins(0, 0, 0, 0));
        emit(18'h3C000);
        release_check();
        wait_done("progD_drain");
        repeat (10) tick();
        chk("progD_halted", halted, 1);
        chk("progD_halt_code_req", code_req, 0);
        chk("progD_halt_data_req", data_req, 0);
        chk("progD_halt_ip", code_addr, 4);
        chk("progD_retire_count", retire_cnt, 4);

        // Reset out of HALT restarts at RESET_IP with halted cleared.
        do_reset();
        emit(18'h3C000);
        release_check();
        wait_done("progE_drain");
        repeat (3) tick();
        chk("progE_halted", halted, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
